bram_stream_reader: RTL and testbench
=====================================

Name: bram_stream_reader

Overview:
Read-side master for one port of the team's BRAM blocks. On a start command it walks a contiguous address window, driving en/addr into the BRAM port. It absorbs the fixed BRAM read latency and presents the words as a valid/ready stream with a last flag. Full backpressure is supported with no lost or duplicated words. It sits between a filled BRAM and a downstream consumer, for example a UART TX or a checker.

Parameters:
RAM_WIDTH, 16, data word width in bits.
RAM_ADDR_BITS, 3, BRAM address width; RAM_DEPTH = 2**RAM_ADDR_BITS.

Ports:
clk_i  input  1  single clock, all logic on rising edge.
rst_i  input  1  asynchronous, active-high reset.
start_i  input  1  start request; sampled only in IDLE.
base_addr_i  input  RAM_ADDR_BITS  first address to read.
len_i  input  RAM_ADDR_BITS+1  word count, 0..RAM_DEPTH.
busy_o  output  1  high from accepted start until done.
done_o  output  1  one-cycle pulse when a transfer completes.
ram_en_o  output  1  BRAM port enable (read only; port we tied 0 externally).
ram_addr_o  output  RAM_ADDR_BITS  BRAM port address.
ram_data_i  input  RAM_WIDTH  BRAM port read data.
data_o  output  RAM_WIDTH  stream data.
valid_o  output  1  stream valid.
ready_i  input  1  stream ready from consumer.
last_o  output  1  marks the final word of the transfer; qualified by valid_o.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. While rst_i is high, all outputs are 0: busy_o, done_o, ram_en_o, ram_addr_o, data_o, valid_o, last_o. The FSM is held in IDLE and the buffer is emptied.
- FSM states:
  - IDLE: start_i=1 and len_i!=0 → READ. Latch base into the address counter and len into both the issue counter and the beat counter. busy_o is set the next cycle.
  - IDLE: start_i=1 and len_i=0 → DONE. No BRAM access occurs.
  - READ: on each cycle with credit available, assert ram_en_o with ram_addr_o = current address. Then increment the address modulo RAM_DEPTH (7 → 0 wraps) and decrement the issue counter. When the issue counter reaches 0 → DRAIN.
  - DRAIN: wait until the beat counter reaches 0 (last beat handshaken) → DONE.
  - DONE: done_o=1 for exactly one cycle, busy_o drops to 0 in the same cycle, then → IDLE.
- Read latency: 1 cycle. Data for an en/addr issued in cycle N is captured from ram_data_i at the end of cycle N+1. A shift register of in-flight flags tracks outstanding reads.
- Buffer and credit:
  - Output buffer is a 2-entry FIFO.
  - Credit rule: issue only if (buffered + in-flight) < 2, which guarantees no overflow under arbitrary ready_i.
  - With ready_i held at 1, throughput is one word per cycle after a 2-cycle start latency: start accepted at edge E, ram_en_o high in cycle E+1, valid_o high in cycle E+2.
- Handshake: a beat transfers when valid_o && ready_i.
  - data_o and last_o stay stable while valid_o=1 and ready_i=0.
  - valid_o never drops without a handshake.
- last_o is 1 on the beat where the beat counter equals 1.
- start_i while busy_o=1 is ignored; it is neither queued nor allowed to disturb the active transfer.
- len_i = RAM_DEPTH reads all words exactly once, wrapping if base is nonzero.
- Reset asserted mid-transfer aborts immediately. No done_o is produced. Any in-flight BRAM data arriving after reset release is discarded.

Optional Feature:
BRAM_READER_OUTREG_EN: when defined, the BRAM is built with its output register enabled.
- Read latency becomes 2 cycles, the in-flight tracker is 2 deep, the output FIFO is 3 entries, and the credit limit is 3.
- Start-to-valid latency becomes 3 cycles; with ready_i=1, throughput stays one word per cycle.
- When undefined, the 1-cycle latency, 2-entry FIFO and credit limit of 2 apply.

Decomposition:
- Package bram_reader_pkg:
  - FSM state enum typedef (IDLE, READ, DRAIN, DONE).
  - localparam RD_LATENCY (1, or 2 under the macro).
  - localparam BUF_DEPTH = RD_LATENCY+1.
- Sub-module bram_reader_fifo: small synchronous FIFO parameterised by width and BUF_DEPTH, with count output. Provides push/pop, data, and valid from the not-empty condition.

Test Plan:
- Fill BRAM words 0..7 with 16'hA000+i, start base=0 len=8, ready_i=1 → valid_o high from E+2 for 8 consecutive cycles, data A000..A007, last_o on A007, then one done_o pulse.
- base=6 len=4 → data order A006, A007, A000, A001; ram_addr_o sequence 6, 7, 0, 1; last_o on A001.
- base=0 len=8, ready_i toggling 1,0,0,1,… random → all 8 words delivered in order, no duplicates, data stable while stalled, ram_en_o never issues more than 2 reads ahead of consumption.
- start with len=0 → no ram_en_o, done_o pulses one cycle later, valid_o stays 0.
- start base=2 len=5, second start at cycle E+3 with base=0 → second start ignored, only A002..A006 delivered.
- rst_i pulsed for 1 cycle after 3 beats of a len=8 transfer → all outputs 0 immediately, no done_o; a fresh start base=0 len=2 then delivers A000, A001 correctly.

Source files
------------

// File: rtl/bram_reader_pkg.sv
// bram_reader_pkg: shared types and latency constants for bram_stream_reader.
// Optional macro BRAM_READER_OUTREG_EN selects the 2-cycle (output-register) BRAM.
package bram_reader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_t;

`ifdef BRAM_READER_OUTREG_EN
  localparam int RD_LATENCY = 2;
`else
  localparam int RD_LATENCY = 1;
`endif

  // One buffer slot per in-flight read plus one for the word on the output.
  localparam int BUF_DEPTH = RD_LATENCY + 1;

endpackage

// File: rtl/bram_stream_reader_if.sv
// bram_stream_reader_if: BRAM read port plus valid/ready output stream.
// master = reader side, slave = BRAM/consumer side.
interface bram_stream_reader_if #(
  parameter int RAM_WIDTH     = 16,
  parameter int RAM_ADDR_BITS = 3
);

  logic                     ram_en_o;
  logic [RAM_ADDR_BITS-1:0] ram_addr_o;
  logic [RAM_WIDTH-1:0]     ram_data_i;
  logic [RAM_WIDTH-1:0]     data_o;
  logic                     valid_o;
  logic                     ready_i;
  logic                     last_o;

  modport master (
    output ram_en_o,
    output ram_addr_o,
    input  ram_data_i,
    output data_o,
    output valid_o,
    input  ready_i,
    output last_o
  );

  modport slave (
    input  ram_en_o,
    input  ram_addr_o,
    output ram_data_i,
    input  data_o,
    input  valid_o,
    output ready_i,
    input  last_o
  );

endinterface

// File: rtl/bram_reader_fifo.sv
// bram_reader_fifo: small synchronous FIFO with occupancy count.
// Ports: clk_i/rst_i, push_i/data_i in, pop_i, data_o/valid_o head, count_o.
module bram_reader_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             data_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             data_o,
  output logic                         valid_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_i) begin
        mem[wr_ptr] <= data_i;
        wr_ptr      <= inc(wr_ptr);
      end
      if (pop_i) rd_ptr <= inc(rd_ptr);
      case ({push_i, pop_i})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign data_o  = mem[rd_ptr];
  assign valid_o = (cnt != '0);
  assign count_o = cnt;

endmodule

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: walks a BRAM address window and streams words out.
// Ports: clk_i, rst_i, start_i, base_addr_i, len_i, busy_o, done_o, bus
// (BRAM en/addr/data + data/valid/ready/last). Macro: BRAM_READER_OUTREG_EN.
module bram_stream_reader
  import bram_reader_pkg::*;
#(
  parameter int RAM_WIDTH     = 16,
  parameter int RAM_ADDR_BITS = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [RAM_ADDR_BITS-1:0] base_addr_i,
  input  logic [RAM_ADDR_BITS:0]   len_i,
  output logic                     busy_o,
  output logic                     done_o,
  bram_stream_reader_if.master     bus
);

  localparam int CW = RAM_ADDR_BITS + 1;
  localparam int FW = $clog2(BUF_DEPTH + 1);

  state_t                   state;
  logic [RAM_ADDR_BITS-1:0] addr_q;
  logic [CW-1:0]            issue_cnt;
  logic [CW-1:0]            beat_cnt;
  logic [RD_LATENCY-1:0]    infl;

  logic                     ram_en;
  logic                     hs;
  logic                     credit;
  logic [3:0]               occ;
  logic [RAM_WIDTH-1:0]     fifo_data;
  logic                     fifo_valid;
  logic [FW-1:0]            fifo_cnt;

  assign hs = fifo_valid & bus.ready_i;

  // Slots claimed = buffered + in flight, less the word leaving this cycle.
  always_comb begin
    occ = 4'(fifo_cnt);
    for (int i = 0; i < RD_LATENCY; i++) begin
      occ = occ + 4'(infl[i]);
    end
    if (hs) occ = occ - 4'd1;
  end

  assign credit = (occ < 4'(BUF_DEPTH));
  assign ram_en = (state == READ) && (issue_cnt != '0) && credit;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      addr_q    <= '0;
      issue_cnt <= '0;
      beat_cnt  <= '0;
      infl      <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      infl   <= RD_LATENCY'({infl, ram_en});
      done_o <= 1'b0;
      if (hs) beat_cnt <= beat_cnt - 1'b1;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            if (len_i != '0) begin
              addr_q    <= base_addr_i;
              issue_cnt <= len_i;
              beat_cnt  <= len_i;
              busy_o    <= 1'b1;
              state     <= READ;
            end else begin
              done_o <= 1'b1;
              state  <= DONE;
            end
          end
        end
        READ: begin
          if (ram_en) begin
            addr_q    <= addr_q + 1'b1;
            issue_cnt <= issue_cnt - 1'b1;
            if (issue_cnt == CW'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (hs && beat_cnt == CW'(1)) begin
            busy_o <= 1'b0;
            done_o <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
      endcase
    end
  end

  bram_reader_fifo #(
    .WIDTH (RAM_WIDTH),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (infl[RD_LATENCY-1]),
    .data_i  (bus.ram_data_i),
    .pop_i   (hs),
    .data_o  (fifo_data),
    .valid_o (fifo_valid),
    .count_o (fifo_cnt)
  );

  assign bus.ram_en_o   = ram_en;
  assign bus.ram_addr_o = addr_q;
  assign bus.data_o     = fifo_data;
  assign bus.valid_o    = fifo_valid;
  assign bus.last_o     = fifo_valid && (beat_cnt == CW'(1));

endmodule

// File: tb/tb_bram_stream_reader.sv
// tb_bram_stream_reader: scoreboard bench with a BRAM model and random ready.
// Expected words/addresses come from the address-window rule, not the RTL.
module tb_bram_stream_reader;

`ifdef BRAM_READER_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int BUF = LAT + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] base;
  logic [3:0] len;
  logic       busy_o;
  logic       done_o;

  bram_stream_reader_if #(.RAM_WIDTH(16), .RAM_ADDR_BITS(3)) bus ();

  bram_stream_reader #(.RAM_WIDTH(16), .RAM_ADDR_BITS(3)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .base_addr_i (base),
    .len_i       (len),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // BRAM model
  logic [15:0] mem [8];
  logic [15:0] q1;
  logic [15:0] q2;
  always @(posedge clk) begin
    if (bus.ram_en_o) q1 <= mem[bus.ram_addr_o];
    q2 <= q1;
  end
`ifdef BRAM_READER_OUTREG_EN
  assign bus.ram_data_i = q2;
`else
  assign bus.ram_data_i = q1;
`endif

  int checks = 0;
  int fails = 0;
  int issued = 0;
  int consumed = 0;
  int n_done = 0;
  bit rnd_ready = 0;

  logic [31:0] exp_data[$];
  logic [31:0] exp_last[$];
  logic [31:0] exp_addr[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Ready driver
  initial begin
    bus.ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor / scoreboard
  bit          stall_q = 0;
  logic [15:0] d_q;
  logic        l_q;
  always @(negedge clk) begin
    if (rst) begin
      stall_q = 0;
    end else begin
      if (stall_q) begin
        chk("stall_valid", 32'(bus.valid_o), 32'd1);
        chk("stall_data", 32'(bus.data_o), 32'(d_q));
        chk("stall_last", 32'(bus.last_o), 32'(l_q));
      end
      if (bus.ram_en_o) begin
        issued++;
        chk("ram_addr", 32'(bus.ram_addr_o),
            exp_addr.size() != 0 ? exp_addr.pop_front() : 32'hDEAD);
      end
      if (bus.valid_o && bus.ready_i) begin
        consumed++;
        chk("data", 32'(bus.data_o),
            exp_data.size() != 0 ? exp_data.pop_front() : 32'hDEAD);
        chk("last", 32'(bus.last_o),
            exp_last.size() != 0 ? exp_last.pop_front() : 32'd2);
      end
      if (bus.ram_en_o)
        chk("reads_ahead", 32'((issued - consumed) <= BUF), 32'd1);
      if (done_o) n_done++;
      stall_q = bus.valid_o && !bus.ready_i;
      d_q = bus.data_o;
      l_q = bus.last_o;
    end
  end

  // Issue a start; called at posedge+1, returns at posedge+1 after edge E.
  task automatic start_xfer(input int b, input int l, input bit accept);
    if (accept) begin
      for (int i = 0; i < l; i++) begin
        exp_addr.push_back(32'((b + i) % 8));
        exp_data.push_back(32'(16'hA000 + 16'((b + i) % 8)));
        exp_last.push_back(32'(i == l - 1));
      end
    end
    start = 1'b1;
    base = 3'(b);
    len = 4'(l);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    bit seen;
    seen = done_o;
    while (!seen && n < budget) begin
      @(posedge clk);
      #1;
      n++;
      if (done_o) seen = 1;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({tag, "_busy_at_done"}, 32'(busy_o), 32'd0);
      @(posedge clk);
      #1;
      chk({tag, "_done_1cyc"}, 32'(done_o), 32'd0);
    end
    chk({tag, "_data_left"}, 32'(exp_data.size()), 32'd0);
    chk({tag, "_addr_left"}, 32'(exp_addr.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int first_v, last_v, nv, done_at, snap, bad;
    for (int i = 0; i < 8; i++) mem[i] = 16'hA000 + 16'(i);
    start = 1'b0;
    base = '0;
    len = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_en", 32'(bus.ram_en_o), 32'd0);
    chk("rst_addr", 32'(bus.ram_addr_o), 32'd0);
    chk("rst_data", 32'(bus.data_o), 32'd0);
    chk("rst_valid", 32'(bus.valid_o), 32'd0);
    chk("rst_last", 32'(bus.last_o), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // full window, ready high: timing
    start_xfer(0, 8, 1);
    chk("t1_busy", 32'(busy_o), 32'd1);
    chk("t1_en", 32'(bus.ram_en_o), 32'd1);
    first_v = -1; last_v = -1; nv = 0; done_at = -1;
    for (int n = 0; n < 40 && done_at < 0; n++) begin
      if (n > 0) begin
        @(posedge clk);
        #1;
      end
      if (bus.valid_o) begin
        if (first_v < 0) first_v = n;
        last_v = n;
        nv++;
      end
      if (done_o) done_at = n;
    end
    chk("t1_first_valid", 32'(first_v), 32'(LAT + 1));
    chk("t1_beats", 32'(nv), 32'd8);
    chk("t1_contiguous", 32'(last_v - first_v), 32'd7);
    chk("t1_done_at", 32'(done_at), 32'(LAT + 9));
    chk("t1_busy_done", 32'(busy_o), 32'd0);
    @(posedge clk);
    #1;
    chk("t1_done_1cyc", 32'(done_o), 32'd0);

    // wrap
    start_xfer(6, 4, 1);
    wait_done("t2", 100);

    // random backpressure
    rnd_ready = 1;
    start_xfer(0, 8, 1);
    wait_done("t3", 300);
    rnd_ready = 0;
    @(posedge clk);
    #1;

    // zero length
    snap = issued;
    start_xfer(0, 0, 1);
    chk("t4_done", 32'(done_o), 32'd1);
    chk("t4_busy", 32'(busy_o), 32'd0);
    chk("t4_valid", 32'(bus.valid_o), 32'd0);
    @(posedge clk);
    #1;
    chk("t4_done_1cyc", 32'(done_o), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("t4_no_reads", 32'(issued - snap), 32'd0);

    // start while busy is ignored
    start_xfer(2, 5, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("t5_busy", 32'(busy_o), 32'd1);
    start_xfer(0, 8, 0);
    wait_done("t5", 100);
    repeat (3) @(posedge clk);
    #1;
    chk("t5_no_extra", 32'(bus.valid_o | bus.ram_en_o), 32'd0);

    // reset mid-transfer
    consumed = 0;
    issued = 0;
    snap = n_done;
    start_xfer(0, 8, 1);
    for (int n = 0; n < 50 && consumed < 3; n++) begin
      @(posedge clk);
      #1;
    end
    chk("t6_three_beats", 32'(consumed >= 3), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_busy", 32'(busy_o), 32'd0);
    chk("t6_done", 32'(done_o), 32'd0);
    chk("t6_en", 32'(bus.ram_en_o), 32'd0);
    chk("t6_addr", 32'(bus.ram_addr_o), 32'd0);
    chk("t6_data", 32'(bus.data_o), 32'd0);
    chk("t6_valid", 32'(bus.valid_o), 32'd0);
    chk("t6_last", 32'(bus.last_o), 32'd0);
    exp_data.delete();
    exp_last.delete();
    exp_addr.delete();
    issued = 0;
    consumed = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bad = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (bus.valid_o || done_o || busy_o) bad++;
    end
    chk("t6_quiet", 32'(bad), 32'd0);
    chk("t6_no_done", 32'(n_done - snap), 32'd0);
    start_xfer(0, 2, 1);
    wait_done("t6", 100);

    // random windows and backpressure
    rnd_ready = 1;
    for (int k = 0; k < 20; k++) begin
      start_xfer(int'($urandom_range(0, 7)), int'($urandom_range(0, 8)), 1);
      wait_done("t7", 300);
    end
    rnd_ready = 0;

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
